load_align_unit: RTL and testbench

- Parametrised, sequential successor to the combinational write-back data formatter.
- Accepts one load request per transaction, issues word-aligned reads to a synchronous data memory, then extracts, aligns and sign/zero-extends the addressed bytes.
- Returns the register write-data over a valid/ready handshake.
- Generalised to XLEN 32/64 and adds misaligned (word-crossing) loads as a two-beat read sequence.
- Sits between the execute-stage ALU address output and the register-file write-back mux.

---
 rtl/load_pkg.sv | 82 ++++++++
 rtl/load_extract.sv | 40 ++++
 rtl/load_align_unit.sv | 170 +++++++++++++++++
 tb/tb_load_align_unit.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_pkg.sv
// Shared definitions for the load alignment unit: load funct3 codes,
// FSM state encoding and the load-size decoder used at request accept.
package load_pkg;

    // Load size/sign codes as they appear in Instruction[14:12]
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LD  = 3'b011;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] LWU = 3'b110;

    typedef enum logic [2:0] {
        IDLE,
        RD0,
        WT0,
        RD1,
        WT1,
        RESP
    } state_t;

    // Decoded view of a funct3 code: byte count, sign-extend flag, legality
    typedef struct packed {
        logic [3:0] size;
        logic       sign;
        logic       legal;
    } load_info_t;

    // Doubleword forms only exist on a 64-bit datapath; everything else
    // outside the five base codes is rejected with size 0.
    function automatic load_info_t decode_load(input logic [2:0] funct3,
                                               input int         xlen);
        load_info_t info;
        info.size  = 4'd0;
        info.sign  = 1'b0;
        info.legal = 1'b0;
        case (funct3)
            LB: begin
                info.size  = 4'd1;
                info.sign  = 1'b1;
                info.legal = 1'b1;
            end
            LH: begin
                info.size  = 4'd2;
                info.sign  = 1'b1;
                info.legal = 1'b1;
            end
            LW: begin
                info.size  = 4'd4;
                info.sign  = 1'b1;
                info.legal = 1'b1;
            end
            LBU: begin
                info.size  = 4'd1;
                info.legal = 1'b1;
            end
            LHU: begin
                info.size  = 4'd2;
                info.legal = 1'b1;
            end
            LWU: begin
                if (xlen == 64) begin
                    info.size  = 4'd4;
                    info.legal = 1'b1;
                end
            end
            LD: begin
                if (xlen == 64) begin
                    info.size  = 4'd8;
                    info.sign  = 1'b1;
                    info.legal = 1'b1;
                end
            end
            default: begin
                info.size  = 4'd0;
            end
        endcase
        return info;
    endfunction

endpackage

// File: rtl/load_extract.sv
// Byte extraction and extension for loads. Takes the two memory words
// {hi, lo}, shifts the addressed bytes down to bit 0 and sign/zero-extends
// the kept field to the full register width.
module load_extract
    import load_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2*XLEN-1:0]          pair,
    input  logic [$clog2(XLEN/8)-1:0]  off,
    input  logic [3:0]                 size,
    input  logic                       sign,
    output logic [XLEN-1:0]            result
);

    localparam int NB = XLEN / 8;

    logic [XLEN-1:0] shifted;
    logic            top_bit;
    logic            fill;

    // Align the addressed bytes to bit 0, then fill bytes above the access
    // size with copies of the field's top bit (signed) or zeros (unsigned).
    always_comb begin
        shifted = XLEN'(pair >> {off, 3'b000});
        top_bit = shifted[XLEN-1];
        case (size)
            4'd1:    top_bit = shifted[7];
            4'd2:    top_bit = shifted[15];
            4'd4:    top_bit = shifted[31];
            default: top_bit = shifted[XLEN-1];
        endcase
        fill   = sign & top_bit;
        result = '0;
        for (int i = 0; i < NB; i++) begin
            result[i*8 +: 8] = (4'(i) < size) ? shifted[i*8 +: 8] : {8{fill}};
        end
    end

endmodule

// File: rtl/load_align_unit.sv
// Sequential load alignment unit. Accepts one load at a time, issues one or
// two word-aligned reads to a synchronous data memory, and returns the
// aligned, extended register write-data over a valid/ready handshake.
module load_align_unit
    import load_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int MISALIGN_EN = 1,
    parameter int AW          = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [AW-1:0]   req_addr,
    input  logic [2:0]      req_funct3,
    input  logic [4:0]      req_rd,
    output logic            mem_rd_en,
    output logic [AW-1:0]   mem_addr,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic [4:0]      resp_rd,
    output logic            resp_err
);

    localparam int            NB        = XLEN / 8;
    localparam int            OFFW      = $clog2(NB);
    localparam logic [AW-1:0] WORD_STEP = AW'(NB);

    state_t          state;

    logic [AW-1:0]   base_q;
    logic [OFFW-1:0] off_q;
    logic [3:0]      size_q;
    logic            sign_q;
    logic            cross_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] lo_q;

    load_info_t      req_info;
    logic [OFFW-1:0] req_off;
    logic [AW-1:0]   req_base;
    logic            req_cross;
    logic            req_reject;

    logic [2*XLEN-1:0] ext_pair;
    logic [XLEN-1:0]   ext_result;

    // Decode the incoming request: size/sign, byte offset inside the word,
    // aligned base address and whether the access spills into the next word.
    always_comb begin
        req_info   = decode_load(req_funct3, XLEN);
        req_off    = req_addr[OFFW-1:0];
        req_base   = {req_addr[AW-1:OFFW], {OFFW{1'b0}}};
        req_cross  = (5'(req_off) + 5'(req_info.size)) > 5'(NB);
        req_reject = !req_info.legal || (req_cross && (MISALIGN_EN == 0));
    end

    // The response is formed on the same edge the last memory word arrives,
    // so the extractor sees live mem_rdata: as lo for a single-word access,
    // as hi (with the saved lo) for the second beat of a crossing access.
    always_comb begin
        ext_pair = {{XLEN{1'b0}}, mem_rdata};
        if (state == WT1) begin
            ext_pair = {mem_rdata, lo_q};
        end
    end

    load_extract #(
        .XLEN (XLEN)
    ) u_extract (
        .pair   (ext_pair),
        .off    (off_q),
        .size   (size_q),
        .sign   (sign_q),
        .result (ext_result)
    );

    // Transaction FSM; every output is registered and updated together with
    // the state it belongs to, so reset in any state drops all strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            mem_rd_en  <= 1'b0;
            mem_addr   <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_rd    <= '0;
            resp_err   <= 1'b0;
            base_q     <= '0;
            off_q      <= '0;
            size_q     <= '0;
            sign_q     <= 1'b0;
            cross_q    <= 1'b0;
            rd_q       <= '0;
            lo_q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        base_q    <= req_base;
                        off_q     <= req_off;
                        size_q    <= req_info.size;
                        sign_q    <= req_info.sign;
                        cross_q   <= req_cross;
                        rd_q      <= req_rd;
                        req_ready <= 1'b0;
                        if (req_reject) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_data  <= '0;
                            resp_rd    <= req_rd;
                        end else begin
                            state     <= RD0;
                            mem_rd_en <= 1'b1;
                            mem_addr  <= req_base;
                        end
                    end
                end
                RD0: begin
                    mem_rd_en <= 1'b0;
                    state     <= WT0;
                end
                WT0: begin
                    lo_q <= mem_rdata;
                    if (cross_q) begin
                        state     <= RD1;
                        mem_rd_en <= 1'b1;
                        mem_addr  <= base_q + WORD_STEP;
                    end else begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_data  <= ext_result;
                        resp_rd    <= rd_q;
                    end
                end
                RD1: begin
                    mem_rd_en <= 1'b0;
                    state     <= WT1;
                end
                WT1: begin
                    state      <= RESP;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_data  <= ext_result;
                    resp_rd    <= rd_q;
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    req_ready  <= 1'b1;
                    mem_rd_en  <= 1'b0;
                    resp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_align_unit.sv
// Directed testbench for load_align_unit. Three instances share one clock
// and reset: 32-bit with misaligned support, 32-bit without, and 64-bit.
// Each has its own synchronous memory model with hand-chosen contents.
module tb_load_align_unit;
    import load_pkg::*;

    logic clk = 1'b0;
    logic reset;

    logic [2:0]       req_valid;
    logic [2:0][31:0] req_addr;
    logic [2:0][2:0]  req_funct3;
    logic [2:0][4:0]  req_rd;
    logic [2:0]       resp_ready;
    logic [2:0][63:0] mem_rdata;

    wire [2:0]        req_ready_v;
    wire [2:0]        mem_rd_en_v;
    wire [2:0][31:0]  mem_addr_v;
    wire [2:0]        resp_valid_v;
    wire [2:0][63:0]  resp_data_v;
    wire [2:0][4:0]   resp_rd_v;
    wire [2:0]        resp_err_v;

    int total = 0;
    int bad   = 0;

    int          rd_count  [3] = '{0, 0, 0};
    logic [31:0] last_addr [3] = '{32'h0, 32'h0, 32'h0};
    logic [31:0] prev_addr [3] = '{32'h0, 32'h0, 32'h0};

    assign resp_data_v[0][63:32] = '0;
    assign resp_data_v[1][63:32] = '0;

    load_align_unit #(.XLEN(32), .MISALIGN_EN(1), .AW(32)) u0 (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid[0]),
        .req_ready  (req_ready_v[0]),
        .req_addr   (req_addr[0]),
        .req_funct3 (req_funct3[0]),
        .req_rd     (req_rd[0]),
        .mem_rd_en  (mem_rd_en_v[0]),
        .mem_addr   (mem_addr_v[0]),
        .mem_rdata  (mem_rdata[0][31:0]),
        .resp_valid (resp_valid_v[0]),
        .resp_ready (resp_ready[0]),
        .resp_data  (resp_data_v[0][31:0]),
        .resp_rd    (resp_rd_v[0]),
        .resp_err   (resp_err_v[0])
    );

    load_align_unit #(.XLEN(32), .MISALIGN_EN(0), .AW(32)) u1 (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid[1]),
        .req_ready  (req_ready_v[1]),
        .req_addr   (req_addr[1]),
        .req_funct3 (req_funct3[1]),
        .req_rd     (req_rd[1]),
        .mem_rd_en  (mem_rd_en_v[1]),
        .mem_addr   (mem_addr_v[1]),
        .mem_rdata  (mem_rdata[1][31:0]),
        .resp_valid (resp_valid_v[1]),
        .resp_ready (resp_ready[1]),
        .resp_data  (resp_data_v[1][31:0]),
        .resp_rd    (resp_rd_v[1]),
        .resp_err   (resp_err_v[1])
    );

    load_align_unit #(.XLEN(64), .MISALIGN_EN(1), .AW(32)) u2 (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid[2]),
        .req_ready  (req_ready_v[2]),
        .req_addr   (req_addr[2]),
        .req_funct3 (req_funct3[2]),
        .req_rd     (req_rd[2]),
        .mem_rd_en  (mem_rd_en_v[2]),
        .mem_addr   (mem_addr_v[2]),
        .mem_rdata  (mem_rdata[2]),
        .resp_valid (resp_valid_v[2]),
        .resp_ready (resp_ready[2]),
        .resp_data  (resp_data_v[2]),
        .resp_rd    (resp_rd_v[2]),
        .resp_err   (resp_err_v[2])
    );

    always #5 clk = ~clk;

    // Fixed memory image per instance; unlisted words read as zero
    function automatic logic [63:0] mem_word(input int u, input logic [31:0] a);
        logic [63:0] w;
        w = '0;
        if (u == 2) begin
            case (a)
                32'h0000_0008: w = 64'h0123_4567_89AB_CDEF;
                32'h0000_0010: w = 64'h1122_3344_5566_7788;
                default:       w = '0;
            endcase
        end else begin
            case (a)
                32'h0000_0100: w = 64'h8899_AABB;
                32'h0000_0104: w = 64'h1122_3344;
                32'hFFFF_FFFC: w = 64'hDEAD_BEEF;
                32'h0000_0000: w = 64'h0403_0201;
                default:       w = '0;
            endcase
        end
        return w;
    endfunction

    // Synchronous memories: data one cycle after the read strobe, plus a log
    // of how many reads each instance issued and the last two addresses
    always @(posedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (mem_rd_en_v[g]) begin
                mem_rdata[g] <= mem_word(g, mem_addr_v[g]);
                rd_count[g]  <= rd_count[g] + 1;
                prev_addr[g] <= last_addr[g];
                last_addr[g] <= mem_addr_v[g];
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Present one request, wait for the response (bounded) and report what
    // came back, how many cycles it took and which words were read
    task automatic applyStimulus(input int u, input logic [31:0] addr,
                                 input logic [2:0] f3, input logic [4:0] rd,
                                 output logic [63:0] data, output logic err,
                                 output logic [4:0] rdo, output int lat,
                                 output int reads, output logic [31:0] a0,
                                 output logic [31:0] a1);
        int c0;
        @(negedge clk);
        checkOutput($sformatf("u%0d ready before accept", u), 64'(req_ready_v[u]), 64'd1);
        c0            = rd_count[u];
        req_valid[u]  = 1'b1;
        req_addr[u]   = addr;
        req_funct3[u] = f3;
        req_rd[u]     = rd;
        @(posedge clk);
        #1 req_valid[u] = 1'b0;
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (resp_valid_v[u]) begin
                lat = n;
                break;
            end
        end
        data  = resp_data_v[u];
        err   = resp_err_v[u];
        rdo   = resp_rd_v[u];
        reads = rd_count[u] - c0;
        a0    = (reads >= 2) ? prev_addr[u] : last_addr[u];
        a1    = last_addr[u];
    endtask

    typedef struct {
        int          u;
        logic [31:0] addr;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [63:0] data;
        logic        err;
        int          lat;
        int          reads;
        logic [31:0] a0;
        logic [31:0] a1;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [63:0] data;
        logic        err;
        logic [4:0]  rdo;
        int          lat;
        int          reads;
        logic [31:0] a0;
        logic [31:0] a1;
        int          c0;
        logic        seen;

        vecs.push_back('{0, 32'h0000_0103, LB,    5'd1,  64'hFFFF_FF88, 1'b0, 3, 1, 32'h100, 32'h0});
        vecs.push_back('{0, 32'h0000_0102, LHU,   5'd2,  64'h0000_8899, 1'b0, 3, 1, 32'h100, 32'h0});
        vecs.push_back('{0, 32'h0000_0100, LW,    5'd3,  64'h8899_AABB, 1'b0, 3, 1, 32'h100, 32'h0});
        vecs.push_back('{0, 32'h0000_0101, LBU,   5'd4,  64'h0000_00AA, 1'b0, 3, 1, 32'h100, 32'h0});
        vecs.push_back('{0, 32'h0000_0100, LH,    5'd5,  64'hFFFF_AABB, 1'b0, 3, 1, 32'h100, 32'h0});
        vecs.push_back('{0, 32'h0000_0102, LW,    5'd6,  64'h3344_8899, 1'b0, 5, 2, 32'h100, 32'h104});
        vecs.push_back('{0, 32'h0000_0103, LH,    5'd7,  64'h0000_4488, 1'b0, 5, 2, 32'h100, 32'h104});
        vecs.push_back('{0, 32'h0000_0106, LH,    5'd8,  64'h0000_1122, 1'b0, 3, 1, 32'h104, 32'h0});
        vecs.push_back('{0, 32'h0000_0104, LB,    5'd9,  64'h0000_0044, 1'b0, 3, 1, 32'h104, 32'h0});
        vecs.push_back('{0, 32'h0000_0100, LD,    5'd10, 64'h0,         1'b1, 1, 0, 32'h0,   32'h0});
        vecs.push_back('{0, 32'h0000_0100, 3'b111,5'd11, 64'h0,         1'b1, 1, 0, 32'h0,   32'h0});
        vecs.push_back('{0, 32'h0000_0100, LWU,   5'd12, 64'h0,         1'b1, 1, 0, 32'h0,   32'h0});
        vecs.push_back('{0, 32'hFFFF_FFFE, LW,    5'd13, 64'h0201_DEAD, 1'b0, 5, 2, 32'hFFFF_FFFC, 32'h0});
        vecs.push_back('{0, 32'hFFFF_FFFF, LBU,   5'd14, 64'h0000_00DE, 1'b0, 3, 1, 32'hFFFF_FFFC, 32'h0});
        vecs.push_back('{1, 32'h0000_0103, LH,    5'd15, 64'h0,         1'b1, 1, 0, 32'h0,   32'h0});
        vecs.push_back('{1, 32'h0000_0100, LW,    5'd16, 64'h8899_AABB, 1'b0, 3, 1, 32'h100, 32'h0});
        vecs.push_back('{1, 32'h0000_0100, LD,    5'd17, 64'h0,         1'b1, 1, 0, 32'h0,   32'h0});
        vecs.push_back('{2, 32'h0000_0008, LD,    5'd18, 64'h0123_4567_89AB_CDEF, 1'b0, 3, 1, 32'h8, 32'h0});
        vecs.push_back('{2, 32'h0000_000C, LW,    5'd19, 64'h0000_0000_0123_4567, 1'b0, 3, 1, 32'h8, 32'h0});
        vecs.push_back('{2, 32'h0000_0008, LW,    5'd20, 64'hFFFF_FFFF_89AB_CDEF, 1'b0, 3, 1, 32'h8, 32'h0});
        vecs.push_back('{2, 32'h0000_0008, LWU,   5'd21, 64'h0000_0000_89AB_CDEF, 1'b0, 3, 1, 32'h8, 32'h0});
        vecs.push_back('{2, 32'h0000_000C, LD,    5'd22, 64'h5566_7788_0123_4567, 1'b0, 5, 2, 32'h8, 32'h10});

        reset      = 1'b1;
        req_valid  = '0;
        req_addr   = '0;
        req_funct3 = '0;
        req_rd     = '0;
        resp_ready = 3'b111;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            checkOutput($sformatf("u%0d reset req_ready", u),  64'(req_ready_v[u]),  64'd1);
            checkOutput($sformatf("u%0d reset mem_rd_en", u),  64'(mem_rd_en_v[u]),  64'd0);
            checkOutput($sformatf("u%0d reset mem_addr", u),   64'(mem_addr_v[u]),   64'd0);
            checkOutput($sformatf("u%0d reset resp_valid", u), 64'(resp_valid_v[u]), 64'd0);
            checkOutput($sformatf("u%0d reset resp_data", u),  resp_data_v[u],       64'd0);
            checkOutput($sformatf("u%0d reset resp_err", u),   64'(resp_err_v[u]),   64'd0);
        end
        reset = 1'b0;

        $display("[TB] running %0d directed vectors", vecs.size());
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].u, vecs[i].addr, vecs[i].f3, vecs[i].rd,
                          data, err, rdo, lat, reads, a0, a1);
            checkOutput($sformatf("v%0d latency", i), 64'(lat),   64'(vecs[i].lat));
            checkOutput($sformatf("v%0d data", i),    data,       vecs[i].data);
            checkOutput($sformatf("v%0d err", i),     64'(err),   64'(vecs[i].err));
            checkOutput($sformatf("v%0d rd", i),      64'(rdo),   64'(vecs[i].rd));
            checkOutput($sformatf("v%0d reads", i),   64'(reads), 64'(vecs[i].reads));
            if (vecs[i].reads > 0)
                checkOutput($sformatf("v%0d addr0", i), 64'(a0), 64'(vecs[i].a0));
            if (vecs[i].reads > 1)
                checkOutput($sformatf("v%0d addr1", i), 64'(a1), 64'(vecs[i].a1));
        end

        // Consumer stall: response must hold and a new request must be ignored
        $display("[TB] stall sequence");
        resp_ready[0] = 1'b0;
        applyStimulus(0, 32'h0000_0100, LW, 5'd25, data, err, rdo, lat, reads, a0, a1);
        checkOutput("stall latency", 64'(lat), 64'd3);
        c0 = rd_count[0];
        for (int k = 0; k < 4; k++) begin
            if (k == 1) begin
                req_valid[0]  = 1'b1;
                req_addr[0]   = 32'h0000_0104;
                req_funct3[0] = LW;
                req_rd[0]     = 5'd26;
            end else begin
                req_valid[0] = 1'b0;
            end
            @(negedge clk);
            checkOutput($sformatf("stall%0d resp_valid", k), 64'(resp_valid_v[0]), 64'd1);
            checkOutput($sformatf("stall%0d resp_data", k),  resp_data_v[0],       64'h8899_AABB);
            checkOutput($sformatf("stall%0d resp_rd", k),    64'(resp_rd_v[0]),    64'd25);
            checkOutput($sformatf("stall%0d req_ready", k),  64'(req_ready_v[0]),  64'd0);
        end
        req_valid[0]  = 1'b0;
        resp_ready[0] = 1'b1;
        @(negedge clk);
        checkOutput("post-handshake resp_valid", 64'(resp_valid_v[0]), 64'd0);
        checkOutput("post-handshake req_ready",  64'(req_ready_v[0]),  64'd1);
        repeat (3) @(negedge clk);
        checkOutput("stall no extra read", 64'(rd_count[0] - c0), 64'd0);
        checkOutput("stall no late resp",  64'(resp_valid_v[0]),  64'd0);

        // Reset during WT0 of a crossing load aborts it before the second read
        $display("[TB] reset-abort sequence");
        @(negedge clk);
        c0            = rd_count[0];
        req_valid[0]  = 1'b1;
        req_addr[0]   = 32'h0000_0102;
        req_funct3[0] = LW;
        req_rd[0]     = 5'd27;
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        @(negedge clk);
        checkOutput("abort RD0 mem_rd_en", 64'(mem_rd_en_v[0]), 64'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("abort req_ready",  64'(req_ready_v[0]),  64'd1);
        checkOutput("abort mem_rd_en",  64'(mem_rd_en_v[0]),  64'd0);
        checkOutput("abort mem_addr",   64'(mem_addr_v[0]),   64'd0);
        checkOutput("abort resp_valid", 64'(resp_valid_v[0]), 64'd0);
        checkOutput("abort resp_data",  resp_data_v[0],       64'd0);
        checkOutput("abort resp_rd",    64'(resp_rd_v[0]),    64'd0);
        checkOutput("abort resp_err",   64'(resp_err_v[0]),   64'd0);
        reset = 1'b0;
        seen  = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            seen = seen | resp_valid_v[0];
        end
        checkOutput("abort single read", 64'(rd_count[0] - c0), 64'd1);
        checkOutput("abort no response", 64'(seen),              64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
